// File: rtl/qam_pkg.sv
// qam_pkg: shared constants and types for the QAM demodulator slice.
//   - per-axis constellation levels and slicing thresholds
//   - 2-bit per-axis codes and the 4-bit symbol type
//   - demodulator FSM state enum
//   - code_level(): maps a 2-bit axis code back to its ideal level
package qam_pkg;

  localparam logic signed [7:0] LVL_NEG_OUT = -8'sd61;
  localparam logic signed [7:0] LVL_NEG_IN  = -8'sd20;
  localparam logic signed [7:0] LVL_POS_IN  =  8'sd20;
  localparam logic signed [7:0] LVL_POS_OUT =  8'sd61;

  localparam logic signed [7:0] TH_LO  = -8'sd41;
  localparam logic signed [7:0] TH_MID =  8'sd0;
  localparam logic signed [7:0] TH_HI  =  8'sd41;

  localparam logic [1:0] CODE_NEG_OUT = 2'b00;
  localparam logic [1:0] CODE_POS_OUT = 2'b01;
  localparam logic [1:0] CODE_NEG_IN  = 2'b10;
  localparam logic [1:0] CODE_POS_IN  = 2'b11;

  localparam int unsigned ERR_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [3:0] symbol_t;

  function automatic logic signed [7:0] code_level(input logic [1:0] code);
    logic signed [7:0] lvl;
    case (code)
      CODE_NEG_OUT: lvl = LVL_NEG_OUT;
      CODE_POS_OUT: lvl = LVL_POS_OUT;
      CODE_NEG_IN:  lvl = LVL_NEG_IN;
      default:      lvl = LVL_POS_IN;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// qam_slicer: combinational single-axis hard-decision slicer.
// Ports:
//   x_i    [7:0] signed  axis sample
//   code_o [1:0]         decided constellation code
//   err_o  [6:0]         |x - level(code)|, forced to 0 when ERR_EN = 0
// Parameter ERR_EN enables the absolute-error path.
module qam_slicer
  import qam_pkg::*;
#(
  parameter bit ERR_EN = 1'b1
) (
  input  logic signed [7:0] x_i,
  output logic [1:0]        code_o,
  output logic [6:0]        err_o
);

  always_comb begin
    if (x_i <= TH_LO) begin
      code_o = CODE_NEG_OUT;
    end else if (x_i < TH_MID) begin
      code_o = CODE_NEG_IN;
    end else if (x_i < TH_HI) begin
      code_o = CODE_POS_IN;
    end else begin
      code_o = CODE_POS_OUT;
    end
  end

  if (ERR_EN) begin : g_err
    logic signed [8:0] diff;
    logic [8:0]        mag;
    logic signed [7:0] lvl;
    always_comb begin
      lvl  = code_level(code_o);
      diff = {x_i[7], x_i} - {lvl[7], lvl};
      mag  = diff[8] ? 9'(-diff) : 9'(diff);
      // worst case is |-128 - (-61)| = 67, so 7 bits suffice
      err_o = mag[6:0];
    end
  end else begin : g_no_err
    assign err_o = '0;
  end

endmodule

// File: rtl/qam_demod.sv
// qam_demod: framed 16-QAM hard-decision demodulator.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   I_data, Q_data 8-bit two's complement sample pair
//   data_valid_i   pair valid this cycle (accepted only in RUN)
//   start          begin a frame (sampled in IDLE only)
//   done_flag_i    last pair of the frame is present or already sent
//   symbol         recovered symbol, [3:2] from I, [1:0] from Q
//   data_valid_o   one-cycle pulse per emitted symbol
//   done_flag_o    one-cycle end-of-frame pulse
//   sym_cnt        symbols emitted in the current frame (wraps)
//   err_acc        (only with QAM_DEMOD_ERR_EN) saturating sum of slicing errors
// Pipeline: stage 1 registers the accepted pair, stage 2 registers the slice.
// FLUSH lasts two cycles so the last accepted pair leaves stage 2 before DONE.
module qam_demod
  import qam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] I_data,
  input  logic [7:0] Q_data,
  input  logic       data_valid_i,
  input  logic       start,
  input  logic       done_flag_i,
  output logic [3:0] symbol,
  output logic       data_valid_o,
  output logic       done_flag_o,
  output logic [7:0] sym_cnt
`ifdef QAM_DEMOD_ERR_EN
  ,
  output logic [11:0] err_acc
`endif
);

`ifdef QAM_DEMOD_ERR_EN
  localparam bit ERR_EN_P = 1'b1;
`else
  localparam bit ERR_EN_P = 1'b0;
`endif

  state_e state_q, state_d;
  logic   flush_q, flush_d;
  logic   accept;
  logic   frame_start;
  logic   done_d;

  logic signed [7:0] i_q, q_q;
  logic              v1_q;
  symbol_t           symbol_q;
  logic              dv_q;
  logic [7:0]        cnt_q;

  logic [1:0] i_code, q_code;
  logic [6:0] i_err, q_err;

  qam_slicer #(.ERR_EN(ERR_EN_P)) u_slice_i (
    .x_i    (i_q),
    .code_o (i_code),
    .err_o  (i_err)
  );

  qam_slicer #(.ERR_EN(ERR_EN_P)) u_slice_q (
    .x_i    (q_q),
    .code_o (q_code),
    .err_o  (q_err)
  );

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    accept      = 1'b0;
    frame_start = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        accept = data_valid_i;
        if (done_flag_i) begin
          state_d = FLUSH;
          flush_d = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_q) begin
          state_d = DONE;
        end else begin
          flush_d = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      i_q      <= '0;
      q_q      <= '0;
      v1_q     <= 1'b0;
      symbol_q <= '0;
      dv_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      v1_q    <= accept;
      if (accept) begin
        i_q <= I_data;
        q_q <= Q_data;
      end
      dv_q <= v1_q;
      if (v1_q) begin
        symbol_q <= {i_code, q_code};
      end
      if (frame_start) begin
        cnt_q <= '0;
      end else if (v1_q) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

`ifdef QAM_DEMOD_ERR_EN
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W:0]   err_sum;

  always_comb begin
    err_sum = {1'b0, err_q} + {6'b0, i_err} + {6'b0, q_err};
    err_d   = err_q;
    if (frame_start) begin
      err_d = '0;
    end else if (v1_q) begin
      err_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_acc = err_q;
`else
  logic unused_err;
  assign unused_err = ^{i_err, q_err};
`endif

  assign symbol       = symbol_q;
  assign data_valid_o = dv_q;
  assign done_flag_o  = done_d;
  assign sym_cnt      = cnt_q;

endmodule

// File: tb/tb_qam_demod.sv
// Self-checking bench for qam_demod: directed table vectors, hand-written
// frame sequences and randomized frames against a behavioural model.
// Define QAM_DEMOD_ERR_EN on both RTL and bench to exercise err_acc.
module tb_qam_demod;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] I_data, Q_data;
  logic       data_valid_i, start, done_flag_i;
  logic [3:0] symbol;
  logic       data_valid_o, done_flag_o;
  logic [7:0] sym_cnt;
`ifdef QAM_DEMOD_ERR_EN
  logic [11:0] err_acc;
`endif

  qam_demod dut (
    .clk          (clk),
    .rst          (rst),
    .I_data       (I_data),
    .Q_data       (Q_data),
    .data_valid_i (data_valid_i),
    .start        (start),
    .done_flag_i  (done_flag_i),
    .symbol       (symbol),
    .data_valid_o (data_valid_o),
    .done_flag_o  (done_flag_o),
    .sym_cnt      (sym_cnt)
`ifdef QAM_DEMOD_ERR_EN
    ,
    .err_acc      (err_acc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- output monitor ----------------
  typedef struct {
    bit         is_done;
    logic [3:0] sym;
    logic [7:0] cnt;
    logic [11:0] err;
    int         c;
  } ev_t;
  ev_t ev_q[$];

  always @(negedge clk) begin
    ev_t e;
    e.c   = cyc;
    e.sym = symbol;
    e.cnt = sym_cnt;
`ifdef QAM_DEMOD_ERR_EN
    e.err = err_acc;
`else
    e.err = '0;
`endif
    if (data_valid_o !== 1'b0) begin
      e.is_done = 1'b0;
      ev_q.push_back(e);
    end
    if (done_flag_o !== 1'b0) begin
      e.is_done = 1'b1;
      ev_q.push_back(e);
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_code(input int x);
    if (x <= -41) return 0;
    else if (x < 0) return 2;
    else if (x <= 40) return 3;
    else return 1;
  endfunction

  function automatic int ref_level(input int code);
    case (code)
      0: return -61;
      1: return 61;
      2: return -20;
      default: return 20;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_sym(input int i, input int q);
    return ref_code(i) * 4 + ref_code(q);
  endfunction

  function automatic int ref_err(input int i, input int q);
    return iabs(i - ref_level(ref_code(i))) + iabs(q - ref_level(ref_code(q)));
  endfunction

  int edge_vals[17] = '{-128, -42, -41, -40, -21, -20, -1, 0, 1, 19, 20, 40, 41, 42, 60, 61, 127};

  function automatic int rand_val();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 255)) - 128;
    return edge_vals[$urandom_range(0, 16)];
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input int i, input int q, input logic v);
    logic [31:0] iv, qv;
    iv = i;
    qv = q;
    I_data       = iv[7:0];
    Q_data       = qv[7:0];
    data_valid_i = v;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_symbol"}, 32'(symbol), 0);
    chk({nm, "_dv"}, 32'(data_valid_o), 0);
    chk({nm, "_done"}, 32'(done_flag_o), 0);
    chk({nm, "_cnt"}, 32'(sym_cnt), 0);
`ifdef QAM_DEMOD_ERR_EN
    chk({nm, "_err"}, 32'(err_acc), 0);
`endif
  endtask

  // Compares the monitor log with the expected symbols followed by one done.
  task automatic check_frame(input string nm, input int exp_sym[$], input int exp_err[$]);
    int acc;
    acc = 0;
    chk({nm, "_event_count"}, ev_q.size(), exp_sym.size() + 1);
    if (ev_q.size() == exp_sym.size() + 1) begin
      for (int k = 0; k < exp_sym.size(); k++) begin
        chk({nm, "_is_sym"}, 32'(ev_q[k].is_done), 0);
        chk({nm, "_symbol"}, 32'(ev_q[k].sym), exp_sym[k]);
        chk({nm, "_sym_cnt"}, 32'(ev_q[k].cnt), (k + 1) % 256);
`ifdef QAM_DEMOD_ERR_EN
        acc = acc + exp_err[k];
        if (acc > 4095) acc = 4095;
        chk({nm, "_err_acc"}, 32'(ev_q[k].err), acc);
`endif
      end
      chk({nm, "_done_last"}, 32'(ev_q[exp_sym.size()].is_done), 1);
      if (exp_sym.size() > 0)
        chk({nm, "_done_after_syms"}, 32'(ev_q[exp_sym.size()].c > ev_q[exp_sym.size() - 1].c), 1);
    end
  endtask

  // One randomized frame: noise in IDLE, start, n RUN cycles (done on the
  // last), then noise including stray start/valid during FLUSH/DONE.
  task automatic run_frame(input string nm, input int n, input bit dense);
    int exp_sym[$];
    int exp_err[$];
    int iv, qv;
    logic v;
    ev_q.delete();
    repeat ($urandom_range(0, 3)) begin
      drive_pair(rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      tick();
    end
    start = 1'b1;
    drive_pair(rand_val(), rand_val(), 1'($urandom_range(0, 1)));
    tick();
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      iv = rand_val();
      qv = rand_val();
      v  = dense ? 1'b1 : 1'($urandom_range(0, 1));
      drive_pair(iv, qv, v);
      done_flag_i = (j == n - 1);
      if (v) begin
        exp_sym.push_back(ref_sym(iv, qv));
        exp_err.push_back(ref_err(iv, qv));
      end
      tick();
    end
    done_flag_i = 1'b0;
    for (int j = 0; j < 6; j++) begin
      drive_pair(rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      start = (j < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
    drive_pair(0, 0, 1'b0);
    tick();
    check_frame(nm, exp_sym, exp_err);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         i;
    int         q;
    logic [3:0] exp_sym;
  } vec_t;
  vec_t tbl[$];

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    int exp_sym[$];
    int exp_err[$];

    tbl.push_back('{-61,  61, 4'b0001});
    tbl.push_back('{-41,  20, 4'b0011});
    tbl.push_back('{-40,  20, 4'b1011});
    tbl.push_back('{ -1,  20, 4'b1011});
    tbl.push_back('{  0,  20, 4'b1111});
    tbl.push_back('{ 40,  20, 4'b1111});
    tbl.push_back('{ 41,  20, 4'b0111});
    tbl.push_back('{-128, 127, 4'b0001});
    tbl.push_back('{127, -128, 4'b0100});

    rst = 1'b0;
    start = 1'b0;
    done_flag_i = 1'b0;
    drive_pair(0, 0, 1'b0);
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // valid pairs in IDLE are discarded
    ev_q.delete();
    drive_pair(61, 61, 1'b1);
    repeat (4) tick();
    drive_pair(0, 0, 1'b0);
    repeat (3) tick();
    chk("idle_discard_events", ev_q.size(), 0);
    chk("idle_sym_cnt", 32'(sym_cnt), 0);

    // table frame: one pair at a time, latency and hold checked per entry
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < tbl.size(); k++) begin
      drive_pair(tbl[k].i, tbl[k].q, 1'b1);
      tick();
      drive_pair(0, 0, 1'b0);
      chk("tbl_dv_stage1", 32'(data_valid_o), 0);
      tick();
      chk("tbl_dv", 32'(data_valid_o), 1);
      chk("tbl_symbol", 32'(symbol), 32'(tbl[k].exp_sym));
      chk("tbl_model_symbol", 32'(symbol), ref_sym(tbl[k].i, tbl[k].q));
      chk("tbl_sym_cnt", 32'(sym_cnt), k + 1);
      tick();
      chk("tbl_dv_pulse", 32'(data_valid_o), 0);
      chk("tbl_symbol_hold", 32'(symbol), 32'(tbl[k].exp_sym));
    end
    done_flag_i = 1'b1;
    tick();
    done_flag_i = 1'b0;
    tick();
    chk("tbl_flush_no_done", 32'(done_flag_o), 0);
    tick();
    chk("tbl_done_pulse", 32'(done_flag_o), 1);
    tick();
    chk("tbl_done_single", 32'(done_flag_o), 0);

    // three back-to-back pairs, done on the third
    ev_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_pair(20, -20, 1'b1);
    tick();
    drive_pair(61, -61, 1'b1);
    tick();
    drive_pair(-20, 20, 1'b1);
    done_flag_i = 1'b1;
    tick();
    drive_pair(0, 0, 1'b0);
    done_flag_i = 1'b0;
    repeat (6) tick();
    exp_sym = '{4'b1110, 4'b0100, 4'b1011};
    exp_err = '{0, 0, 0};
    check_frame("three_pair", exp_sym, exp_err);
    if (ev_q.size() == 4)
      chk("three_pair_done_next_cycle", ev_q[3].c - ev_q[2].c, 1);
    chk("three_pair_final_cnt", 32'(sym_cnt), 3);

`ifdef QAM_DEMOD_ERR_EN
    ev_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_pair(-50, 25, 1'b1);
    tick();
    drive_pair(127, -128, 1'b1);
    done_flag_i = 1'b1;
    tick();
    drive_pair(0, 0, 1'b0);
    done_flag_i = 1'b0;
    repeat (5) tick();
    if (ev_q.size() >= 2) begin
      chk("err_first", 32'(ev_q[0].err), 16);
      chk("err_second", 32'(ev_q[1].err), 149);
    end else begin
      chk("err_event_count", ev_q.size(), 3);
    end
    chk("err_final", 32'(err_acc), 149);
`endif

    // reset one cycle after acceptance drops the in-flight symbol
    ev_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_pair(61, 61, 1'b1);
    tick();
    drive_pair(0, 0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_all_zero("midreset");
    repeat (6) tick();
    chk("midreset_no_events", ev_q.size(), 0);
    // still in IDLE: a valid pair without start must be dropped
    drive_pair(-61, -61, 1'b1);
    repeat (3) tick();
    drive_pair(0, 0, 1'b0);
    repeat (3) tick();
    chk("midreset_idle_events", ev_q.size(), 0);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      run_frame("rand_frame", $urandom_range(1, 12), 1'b0);
    end
    run_frame("wrap_frame", 270, 1'b1);
    run_frame("after_wrap_frame", 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
